// File: rtl/gray_code_source.sv
// Gray-code stream source with valid/ready output handshake.
// Supports free-run and single-sweep modes, up/down counting and load.
module gray_code_source #(
    parameter int WIDTH = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             stop,
    input  logic             dir,
    input  logic             sweep,
    input  logic             load,
    input  logic [WIDTH-1:0] load_bin,
    output logic [WIDTH-1:0] g_out,
    output logic             g_valid,
    input  logic             g_ready,
    output logic             wrap,
    output logic             done,
    output logic             busy
);

    localparam logic S_IDLE = 1'b0;
    localparam logic S_RUN  = 1'b1;

    localparam logic [WIDTH-1:0] CNT_ONE   = 1;
    localparam logic [WIDTH:0]   XFER_ONE  = 1;
    localparam logic [WIDTH:0]   SWEEP_LEN = {1'b1, {WIDTH{1'b0}}};

    logic             r_state;
    logic [WIDTH-1:0] r_cnt;
    logic [WIDTH-1:0] r_g;
    logic [WIDTH:0]   r_xfer;
    logic             r_sweep;
    logic             r_wrap;
    logic             r_done;

    logic             w_hs;
    logic             w_load;
    logic [WIDTH-1:0] w_cnt_step;
    logic [WIDTH-1:0] w_cnt_next;
    logic             w_wrap_step;
    logic [WIDTH:0]   w_xfer_next;
    logic             w_last;

    assign w_hs        = (r_state == S_RUN) && g_ready;
    assign w_load      = (r_state == S_IDLE) && !stop && load;
    assign w_cnt_step  = dir ? (r_cnt - CNT_ONE) : (r_cnt + CNT_ONE);
    assign w_wrap_step = dir ? (r_cnt == '0) : (r_cnt == '1);
    assign w_xfer_next = r_xfer + XFER_ONE;
    // A sweep ends on the handshake that completes 2^WIDTH transfers.
    assign w_last      = r_sweep && (w_xfer_next == SWEEP_LEN);

    always_comb begin
        w_cnt_next = r_cnt;
        if (w_load) begin
            w_cnt_next = load_bin;
        end else if (w_hs) begin
            w_cnt_next = w_cnt_step;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= S_IDLE;
            r_cnt   <= '0;
            r_g     <= '0;
            r_xfer  <= '0;
            r_sweep <= 1'b0;
            r_wrap  <= 1'b0;
            r_done  <= 1'b0;
        end else begin
            r_wrap <= 1'b0;
            r_done <= 1'b0;
            r_cnt  <= w_cnt_next;
            r_g    <= w_cnt_next ^ (w_cnt_next >> 1);
            if (r_state == S_IDLE) begin
                if (!stop && !load && start) begin
                    r_state <= S_RUN;
                    r_xfer  <= '0;
                    r_sweep <= sweep;
                end
            end else begin
                if (w_hs) begin
                    r_xfer <= w_xfer_next;
                    r_wrap <= w_wrap_step;
                    if (w_last) begin
                        r_state <= S_IDLE;
                        r_done  <= 1'b1;
                    end
                end
                if (stop) begin
                    r_state <= S_IDLE;
                end
            end
        end
    end

    assign g_out   = r_g;
    assign g_valid = (r_state == S_RUN);
    assign busy    = (r_state == S_RUN);
    assign wrap    = r_wrap;
    assign done    = r_done;

endmodule

// File: tb/tb_gray_code_source.sv
// Self-checking bench for gray_code_source (WIDTH=4): directed vector
// table, sweep sequences and randomized run against a reference model.
module tb_gray_code_source;

    logic       clk = 1'b0;
    logic       rst, start, stop, dir, sweep, load, g_ready;
    logic [3:0] load_bin;
    logic [3:0] g_out;
    logic       g_valid, wrap, done, busy;

    int checks   = 0;
    int failures = 0;

    always #5 clk = ~clk;

    gray_code_source #(.WIDTH(4)) dut (
        .clk     (clk),
        .rst     (rst),
        .start   (start),
        .stop    (stop),
        .dir     (dir),
        .sweep   (sweep),
        .load    (load),
        .load_bin(load_bin),
        .g_out   (g_out),
        .g_valid (g_valid),
        .g_ready (g_ready),
        .wrap    (wrap),
        .done    (done),
        .busy    (busy)
    );

    typedef struct {
        logic       rst, start, stop, dir, sweep, load;
        logic [3:0] ld;
        logic       rdy;
        logic [3:0] eg;
        logic       ev, ew, ed;
    } vec_t;

    vec_t vq[$];

    function automatic vec_t mk(logic r, logic s, logic p, logic d,
                                logic w, logic l, logic [3:0] ld,
                                logic rd, logic [3:0] eg, logic ev,
                                logic ew, logic ed);
        vec_t v;
        v.rst = r; v.start = s; v.stop = p; v.dir = d;
        v.sweep = w; v.load = l; v.ld = ld; v.rdy = rd;
        v.eg = eg; v.ev = ev; v.ew = ew; v.ed = ed;
        return v;
    endfunction

    task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    task automatic step(logic r, logic s, logic p, logic d, logic w,
                        logic l, logic [3:0] ld, logic rd);
        @(negedge clk);
        rst = r; start = s; stop = p; dir = d;
        sweep = w; load = l; load_bin = ld; g_ready = rd;
        @(posedge clk);
        #1;
    endtask

    function automatic logic [3:0] gray(int b);
        logic [3:0] v;
        v = 4'(b);
        return v ^ (v >> 1);
    endfunction

    // Reference model state (plain integers, spec-level behaviour)
    bit m_run;
    int m_cnt, m_xfer;
    bit m_sw;

    initial begin
        int hs, dc;
        logic [3:0] up_seq[16];
        rst = 1'b1; start = 0; stop = 0; dir = 0;
        sweep = 0; load = 0; load_bin = 0; g_ready = 0;

        // reset, then reset while in RUN
        vq.push_back(mk(1,0,0,0,0,0,0,0, 4'b0000,0,0,0));
        vq.push_back(mk(0,1,0,0,0,0,0,0, 4'b0000,1,0,0));
        vq.push_back(mk(0,0,0,0,0,0,0,1, 4'b0001,1,0,0));
        vq.push_back(mk(1,0,0,0,0,0,0,1, 4'b0000,0,0,0));
        vq.push_back(mk(1,1,0,0,0,0,0,1, 4'b0000,0,0,0));
        // up free-run with backpressure at 0011
        vq.push_back(mk(0,1,0,0,0,0,0,1, 4'b0000,1,0,0));
        vq.push_back(mk(0,0,0,0,0,0,0,1, 4'b0001,1,0,0));
        vq.push_back(mk(0,0,0,0,0,0,0,1, 4'b0011,1,0,0));
        vq.push_back(mk(0,1,0,0,0,0,0,0, 4'b0011,1,0,0));
        vq.push_back(mk(0,0,0,0,0,1,9,0, 4'b0011,1,0,0));
        vq.push_back(mk(0,0,0,0,0,0,0,0, 4'b0011,1,0,0));
        vq.push_back(mk(0,0,0,0,0,0,0,0, 4'b0011,1,0,0));
        vq.push_back(mk(0,0,0,0,0,0,0,0, 4'b0011,1,0,0));
        up_seq = '{4'b0010,4'b0110,4'b0111,4'b0101,4'b0100,4'b1100,
                   4'b1101,4'b1111,4'b1110,4'b1010,4'b1011,4'b1001,
                   4'b1000,4'b0000,4'b0001,4'b0011};
        for (int i = 0; i < 15; i++)
            vq.push_back(mk(0,0,0,0,0,0,0,1, up_seq[i],1,
                            (i == 13),0));
        // stop, load priority over start, down count and down wrap
        vq.push_back(mk(0,0,1,0,0,0,0,0, 4'b0001,0,0,0));
        vq.push_back(mk(0,1,0,0,0,1,5,0, 4'b0111,0,0,0));
        vq.push_back(mk(0,1,0,1,0,0,0,0, 4'b0111,1,0,0));
        vq.push_back(mk(0,0,0,1,0,0,0,1, 4'b0110,1,0,0));
        vq.push_back(mk(0,0,0,1,0,0,0,1, 4'b0010,1,0,0));
        vq.push_back(mk(0,0,0,1,0,0,0,1, 4'b0011,1,0,0));
        vq.push_back(mk(0,0,0,1,0,0,0,1, 4'b0001,1,0,0));
        vq.push_back(mk(0,0,0,1,0,0,0,1, 4'b0000,1,0,0));
        vq.push_back(mk(0,0,0,1,0,0,0,1, 4'b1000,1,1,0));
        // stop with a handshake still advances; stop beats load
        vq.push_back(mk(0,0,1,1,0,0,0,1, 4'b1001,0,0,0));
        vq.push_back(mk(0,0,1,0,0,1,3,0, 4'b1001,0,0,0));

        foreach (vq[i]) begin
            step(vq[i].rst, vq[i].start, vq[i].stop, vq[i].dir,
                 vq[i].sweep, vq[i].load, vq[i].ld, vq[i].rdy);
            chk($sformatf("vec%0d g_out", i), g_out, vq[i].eg);
            chk($sformatf("vec%0d g_valid", i), g_valid, vq[i].ev);
            chk($sformatf("vec%0d busy", i), busy, vq[i].ev);
            chk($sformatf("vec%0d wrap", i), wrap, vq[i].ew);
            chk($sformatf("vec%0d done", i), done, vq[i].ed);
        end

        // full sweep from cnt=14
        step(0,1,0,0,1,0,0,1);
        chk("sweep start valid", g_valid, 1);
        hs = 0; dc = 0;
        for (int i = 0; i < 40; i++) begin
            if (!busy) break;
            if (g_valid && g_ready) hs++;
            step(0,0,0,0,0,0,0,1);
            dc += int'(done);
        end
        chk("sweep handshakes", hs, 16);
        chk("sweep done pulses", dc, 1);
        chk("sweep busy end", busy, 0);
        chk("sweep g_out end", g_out, 4'b1001);
        step(0,0,0,0,0,0,0,1);
        chk("sweep done one cycle", done, 0);

        // stop coinciding with the final sweep handshake
        step(0,1,0,0,1,0,0,0);
        dc = 0;
        for (int i = 0; i < 15; i++) begin
            step(0,0,0,0,0,0,0,1);
            dc += int'(done);
        end
        chk("sweep stop early done", dc, 0);
        chk("sweep stop busy pre", busy, 1);
        step(0,0,1,0,0,0,0,1);
        chk("sweep stop done", done, 1);
        chk("sweep stop busy", busy, 0);
        chk("sweep stop g_out", g_out, 4'b1001);

        // randomized run against the reference model
        m_run = 0; m_cnt = 0; m_xfer = 0; m_sw = 0;
        for (int i = 0; i < 400; i++) begin
            logic r, s, p, d, w, l, rd;
            logic [3:0] ld;
            bit ew, ed;
            int nc;
            r  = (i == 0) || ($urandom_range(0, 60) == 0);
            s  = ($urandom_range(0, 3) == 0);
            p  = ($urandom_range(0, 25) == 0);
            d  = $urandom_range(0, 1);
            w  = $urandom_range(0, 1);
            l  = ($urandom_range(0, 7) == 0);
            ld = 4'($urandom);
            rd = ($urandom_range(0, 9) < 7);
            ew = 0; ed = 0;
            if (r) begin
                m_run = 0; m_cnt = 0; m_xfer = 0; m_sw = 0;
            end else if (!m_run) begin
                if (p) begin
                end else if (l) begin
                    m_cnt = int'(ld);
                end else if (s) begin
                    m_run = 1; m_xfer = 0; m_sw = w;
                end
            end else begin
                if (rd) begin
                    nc = d ? (m_cnt + 15) % 16 : (m_cnt + 1) % 16;
                    ew = d ? (nc == 15) : (nc == 0);
                    m_cnt = nc;
                    m_xfer++;
                    if (m_sw && m_xfer == 16) begin
                        m_run = 0; ed = 1;
                    end
                end
                if (p) m_run = 0;
            end
            step(r, s, p, d, w, l, ld, rd);
            chk($sformatf("rnd%0d g_out", i), g_out, gray(m_cnt));
            chk($sformatf("rnd%0d g_valid", i), g_valid, m_run);
            chk($sformatf("rnd%0d busy", i), busy, m_run);
            chk($sformatf("rnd%0d wrap", i), wrap, ew);
            chk($sformatf("rnd%0d done", i), done, ed);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/gray_code_source.md
GRAY_CODE_SOURCE -- requirements
Module: gray_code_source

Interface
REQ-001 SHALL have parameter WIDTH, default 4, giving the code width in bits (legal range 2..16).
REQ-002 SHALL have port clk, input, 1 bit: the single clock; all state updates occur on its rising edge.
REQ-003 SHALL have port rst, input, 1 bit: synchronous, active-high reset sampled on the rising edge of clk.
REQ-004 SHALL have port start, input, 1 bit: begin emitting codes while in IDLE.
REQ-005 SHALL have port stop, input, 1 bit: abort emission and return to IDLE.
REQ-006 SHALL have port dir, input, 1 bit: count direction, 0 for up and 1 for down, sampled at each handshake.
REQ-007 SHALL have port sweep, input, 1 bit: sampled with start; 1 selects a single full sweep and 0 selects free-run.
REQ-008 SHALL have port load, input, 1 bit: load the count from load_bin, honoured in IDLE only.
REQ-009 SHALL have port load_bin, input, WIDTH bits: binary load value.
REQ-010 SHALL have port g_out, output, WIDTH bits: Gray code of the current count, g_out = cnt XOR (cnt >> 1).
REQ-011 SHALL have port g_valid, output, 1 bit: g_out is offered to the downstream Gray-to-binary stage.
REQ-012 SHALL have port g_ready, input, 1 bit: the downstream stage accepts g_out.
REQ-013 SHALL have port wrap, output, 1 bit: one-cycle pulse on a count wrap.
REQ-014 SHALL have port done, output, 1 bit: one-cycle pulse at the end of a sweep.
REQ-015 SHALL have port busy, output, 1 bit: high whenever the state is not IDLE.

Function
REQ-016 SHALL hold an internal WIDTH-bit binary count cnt and a (WIDTH+1)-bit transfer counter xfer.
REQ-017 SHALL drive g_out, g_valid, wrap, done and busy from registers or from registered state only, with no combinational path from any input.
REQ-018 SHALL implement exactly two states: IDLE (g_valid=0) and RUN (g_valid=1).
REQ-019 SHALL define a handshake as g_valid=1 and g_ready=1 in the same cycle; cnt SHALL change only on a handshake or a load.
REQ-020 SHALL, on each handshake, set cnt to cnt+1 if dir=0 or cnt-1 if dir=1, modulo 2^WIDTH, and increment xfer.
REQ-021 SHALL, in the cycle after a handshake, present a g_out that differs from the previous g_out in exactly one bit.
REQ-022 SHALL hold g_out stable while g_valid=1 and g_ready=0, for any number of cycles.
REQ-023 SHALL pulse wrap in the cycle after a handshake that moves cnt from 2^WIDTH-1 to 0 (up) or from 0 to 2^WIDTH-1 (down).
REQ-024 SHALL, in IDLE with start=1, move to RUN next cycle, clear xfer, and latch sweep; g_valid SHALL rise one cycle after start.
REQ-025 SHALL, in IDLE with load=1, set cnt to load_bin next cycle; load SHALL take priority over start in the same cycle, so start is ignored.
REQ-026 SHALL ignore load in RUN.
REQ-027 SHALL ignore start in RUN.
REQ-028 SHALL, in RUN with stop=1, return to IDLE next cycle; a handshake in the same cycle SHALL complete and advance cnt.
REQ-029 SHALL, in sweep mode, return to IDLE and pulse done in the cycle after the 2^WIDTH-th handshake; cnt then equals its value at start.
REQ-030 SHALL, if stop and the final sweep handshake coincide, go to IDLE and still pulse done.
REQ-031 SHALL never pulse done in free-run mode.
REQ-032 SHALL allow dir to change between handshakes; the direction SHALL apply to the next handshake only.
REQ-033 SHALL apply input priority in the order rst > stop > load > start.

Reset
REQ-034 SHALL, on rst=1 at a rising clk edge, set state=IDLE, cnt=0, xfer=0, g_out=0, g_valid=0, wrap=0, done=0, busy=0.
REQ-035 SHALL give reset priority over all other inputs, and SHALL abort any transfer in progress when asserted in RUN; the following cycle SHALL show g_valid=0.

Verification
REQ-036 SHALL be verified for reset with WIDTH=4: rst high 2 cycles in RUN -> g_out=0000, g_valid=0, busy=0.
REQ-037 SHALL be verified for an up free-run: start, dir=0, g_ready=1 -> g_out 0000,0001,0011,0010,0110,...,1000,0000 with wrap pulsed at the 1000->0000 step.
REQ-038 SHALL be verified for backpressure: g_ready=0 for 5 cycles at g_out=0011 -> g_out stays 0011 and cnt is unchanged, then advances to 0010 after g_ready rises.
REQ-039 SHALL be verified for load plus down-count: load_bin=5 in IDLE then start with dir=1 -> g_out 0111, 0110, 0010 (binary 5, 4, 3).
REQ-040 SHALL be verified for a down wrap: from cnt=0 with dir=1, one handshake -> g_out=1000 (binary 15) and wrap pulsed.
REQ-041 SHALL be verified for a sweep: sweep=1, g_ready=1 -> exactly 16 handshakes, done pulses once, busy falls, and g_out returns to the start code.
